// File: rtl/cntr_updn_mod_nb_if.sv
// Control/status bundle for the up/down modulo counter.
// master drives controls (en..cmp); slave returns count, rco, tc_pulse, cmp_match.
interface cntr_updn_mod_nb_if #(
  parameter int n     = 8,
  parameter int PRE_W = 4
);
  logic             en;
  logic             up;
  logic             ld;
  logic [n-1:0]     D;
  logic [n-1:0]     max;
  logic             sat;
  logic [PRE_W-1:0] presc;
  logic [n-1:0]     cmp;
  logic [n-1:0]     count;
  logic             rco;
  logic             tc_pulse;
  logic             cmp_match;

  modport master (
    output en, up, ld, D, max, sat, presc, cmp,
    input  count, rco, tc_pulse, cmp_match
  );

  modport slave (
    input  en, up, ld, D, max, sat, presc, cmp,
    output count, rco, tc_pulse, cmp_match
  );
endinterface

// File: rtl/cntr_updn_mod_nb.sv
// n-bit up/down counter, range 0..max, wrap/saturate, prescaler, compare pulse.
// Ports: clk, clr (async, active-high), bus (slave side of cntr_updn_mod_nb_if).
module cntr_updn_mod_nb #(
  parameter int n     = 8,
  parameter int PRE_W = 4
) (
  input logic             clk,
  input logic             clr,
  cntr_updn_mod_nb_if.slave bus
);

  logic [n-1:0]     count_q, count_d;
  logic [PRE_W-1:0] p_q, p_d;
  logic             tc_q, tc_d;
  logic             cm_q, cm_d;
  logic             tick;
  logic [n-1:0]     dec;

  assign tick = bus.en & (p_q == bus.presc);
  assign dec  = count_q - n'(1);

  always_comb begin
    count_d = count_q;
    p_d     = p_q;
    tc_d    = 1'b0;
    cm_d    = 1'b0;
    if (bus.ld) begin
      p_d     = '0;
      count_d = (bus.D > bus.max) ? bus.max : bus.D;
      cm_d    = (count_d == bus.cmp);
    end else if (bus.en) begin
      p_d = tick ? '0 : p_q + PRE_W'(1);
      if (tick) begin
        if (bus.up) begin
          if (count_q < bus.max) begin
            count_d = count_q + n'(1);
          end else begin
            count_d = bus.sat ? bus.max : '0;
            tc_d    = 1'b1;
          end
        end else begin
          if (count_q != '0) begin
            // max may have been lowered below count
            count_d = (dec > bus.max) ? bus.max : dec;
          end else begin
            count_d = bus.sat ? '0 : bus.max;
            tc_d    = 1'b1;
          end
        end
        // no pulse when a step leaves count where it was
        cm_d = (count_d == bus.cmp) && (count_d != count_q);
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count_q <= '0;
      p_q     <= '0;
      tc_q    <= 1'b0;
      cm_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      p_q     <= p_d;
      tc_q    <= tc_d;
      cm_q    <= cm_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.tc_pulse  = tc_q;
  assign bus.cmp_match = cm_q;
  assign bus.rco = (bus.up & (count_q >= bus.max))
                 | (~bus.up & (count_q == '0));

endmodule

// File: tb/tb_cntr_updn_mod_nb.sv
// Self-checking bench for cntr_updn_mod_nb.
// Directed scenarios then random traffic against an integer reference model.
module tb_cntr_updn_mod_nb;
  localparam int N  = 8;
  localparam int PW = 4;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int tests = 0;
  int fails = 0;

  int mc, mp;
  int mtc, mcm;

  cntr_updn_mod_nb_if #(.n(N), .PRE_W(PW)) bus ();

  cntr_updn_mod_nb #(.n(N), .PRE_W(PW)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int r;
    r = bus.up ? int'(mc >= int'(bus.max)) : int'(mc == 0);
    chk({tag, ".count"}, 32'(bus.count), mc);
    chk({tag, ".tc"}, 32'(bus.tc_pulse), mtc);
    chk({tag, ".cmp"}, 32'(bus.cmp_match), mcm);
    chk({tag, ".rco"}, 32'(bus.rco), r);
  endtask

  task automatic model_reset();
    mc = 0; mp = 0; mtc = 0; mcm = 0;
  endtask

  // Inputs are already set; predict, clock, then compare.
  task automatic cyc(input string tag);
    int nc, np, ntc, ncm, mx, d;
    mx = int'(bus.max);
    d  = int'(bus.D);
    nc = mc; np = mp; ntc = 0; ncm = 0;
    if (bus.ld) begin
      np  = 0;
      nc  = (d > mx) ? mx : d;
      ncm = int'(nc == int'(bus.cmp));
    end else if (bus.en) begin
      if (mp == int'(bus.presc)) begin
        np = 0;
        if (bus.up) begin
          if (mc < mx) nc = mc + 1;
          else begin nc = bus.sat ? mx : 0; ntc = 1; end
        end else begin
          if (mc > 0) nc = (mc - 1 > mx) ? mx : mc - 1;
          else begin nc = bus.sat ? 0 : mx; ntc = 1; end
        end
        ncm = int'(nc == int'(bus.cmp) && nc != mc);
      end else begin
        np = (mp + 1) % (1 << PW);
      end
    end
    @(posedge clk);
    #1;
    mc = nc; mp = np; mtc = ntc; mcm = ncm;
    check_all(tag);
  endtask

  task automatic async_clr();
    #2 clr = 1'b1;
    #1;
    chk("aclr.count", 32'(bus.count), 0);
    chk("aclr.tc", 32'(bus.tc_pulse), 0);
    chk("aclr.cmp", 32'(bus.cmp_match), 0);
    clr = 1'b0;
    model_reset();
  endtask

  initial begin
    bus.en = 0; bus.up = 1; bus.ld = 0; bus.D = '0;
    bus.max = 8'd9; bus.sat = 0; bus.presc = '0; bus.cmp = 8'd200;
    model_reset();
    #3;
    chk("rst.count", 32'(bus.count), 0);
    chk("rst.tc", 32'(bus.tc_pulse), 0);
    chk("rst.cmp", 32'(bus.cmp_match), 0);
    @(negedge clk);
    clr = 1'b0;

    // wrap up-count 0..9
    bus.en = 1;
    for (int i = 0; i < 12; i++) cyc("wrap9");

    // prescale by 4 with enable gaps
    bus.presc = 4'd3; bus.max = 8'd255;
    for (int i = 0; i < 6; i++) cyc("pre4a");
    bus.en = 0;
    for (int i = 0; i < 2; i++) cyc("pre4off");
    bus.en = 1;
    for (int i = 0; i < 9; i++) cyc("pre4b");

    // saturating down count from 2, cmp at 0
    bus.presc = '0; bus.max = 8'd9; bus.sat = 1; bus.up = 0;
    bus.cmp = 8'd0; bus.ld = 1; bus.D = 8'd2;
    cyc("satld");
    bus.ld = 0;
    for (int i = 0; i < 4; i++) cyc("satdn");

    // load clamped to max, then wrap up
    bus.sat = 0; bus.max = 8'd50; bus.cmp = 8'd200;
    bus.en = 0; bus.ld = 1; bus.D = 8'd200;
    cyc("clampld");
    bus.ld = 0; bus.en = 1; bus.up = 1;
    cyc("clampwrap");

    // load coinciding with a tick resets the prescaler
    bus.presc = 4'd3; bus.max = 8'd100;
    for (int i = 0; i < 3; i++) cyc("preld");
    bus.ld = 1; bus.D = 8'd7; bus.cmp = 8'd7;
    cyc("ldtick");
    bus.ld = 0;
    for (int i = 0; i < 6; i++) cyc("afterld");
    async_clr();
    for (int i = 0; i < 5; i++) cyc("afterclr");

    // max = 0 pins count
    bus.presc = '0; bus.max = 8'd0; bus.cmp = 8'd5;
    for (int i = 0; i < 4; i++) cyc("max0up");
    bus.up = 0;
    for (int i = 0; i < 4; i++) cyc("max0dn");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bus.en    = ($urandom_range(0, 9) != 0);
      bus.up    = 1'($urandom);
      bus.ld    = ($urandom_range(0, 11) == 0);
      bus.sat   = 1'($urandom);
      bus.D     = 8'($urandom);
      bus.cmp   = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 19) == 0)
        bus.max = 8'(($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 12));
      if ($urandom_range(0, 29) == 0)
        bus.presc = 4'($urandom_range(0, 3));
      cyc("rand");
      if ($urandom_range(0, 99) == 0) async_clr();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
